// File: rtl/wu_memory_queue_pkg.sv
// Shared types and layout helpers for the WU instruction store.
// A word is packed LSB first as icntl, dcntl, op, then {type,value} per option.
package wu_memory_queue_pkg;

  localparam int DEF_NUM_OPT     = 3;
  localparam int DEF_OPT_TYPE_W  = 8;
  localparam int DEF_OPT_VALUE_W = 8;
  localparam int DEF_OP_W        = 2;
  localparam int DEF_CNTL_W      = 2;

  function automatic int word_w(input int num_opt, input int opt_type_w,
                                input int opt_value_w, input int op_w, input int cntl_w);
    return 2 * cntl_w + op_w + num_opt * (opt_type_w + opt_value_w);
  endfunction

  function automatic int icntl_lsb();
    return 0;
  endfunction

  function automatic int dcntl_lsb(input int cntl_w);
    return cntl_w;
  endfunction

  function automatic int op_lsb(input int cntl_w);
    return 2 * cntl_w;
  endfunction

  function automatic int opt_lsb(input int cntl_w, input int op_w);
    return 2 * cntl_w + op_w;
  endfunction

  typedef enum logic [DEF_OP_W-1:0] {
    OP_NOP = 2'd0,
    OP_OP  = 2'd1,
    OP_MR  = 2'd2,
    OP_MW  = 2'd3
  } wu_op_e;

  typedef struct packed {
    logic [DEF_OPT_VALUE_W-1:0] value;
    logic [DEF_OPT_TYPE_W-1:0]  otype;
  } wu_opt_t;

  // Declared MSB first so a cast from a raw word lines up with the LSB-first layout.
  typedef struct packed {
    wu_opt_t [DEF_NUM_OPT-1:0] opt;
    wu_op_e                    op;
    logic [DEF_CNTL_W-1:0]     dcntl;
    logic [DEF_CNTL_W-1:0]     icntl;
  } wu_inst_t;

endpackage

// File: rtl/wu_memory_queue_if.sv
// Fetch, load and decode connections of the WU instruction store.
// master = surrounding manager logic, slave = the store itself.
interface wu_memory_queue_if #(
  parameter int ADDR_W      = 8,
  parameter int WORD_W      = 54,
  parameter int NUM_OPT     = 3,
  parameter int OPT_TYPE_W  = 8,
  parameter int OPT_VALUE_W = 8,
  parameter int OP_W        = 2,
  parameter int CNTL_W      = 2,
  parameter int MGR_ID_W    = 8
);
  logic [MGR_ID_W-1:0]            sys__mgr__mgrId;
  logic                           wuf__wum__read;
  logic [ADDR_W-1:0]              wuf__wum__addr;
  logic                           wuf__wum__flush;
  logic                           wum__wuf__stall;
  logic                           ld__wum__write;
  logic [ADDR_W-1:0]              ld__wum__addr;
  logic [WORD_W-1:0]              ld__wum__data;
  logic                           wum__wud__valid;
  logic                           wud__wum__ready;
  logic [CNTL_W-1:0]              wum__wud__icntl;
  logic [CNTL_W-1:0]              wum__wud__dcntl;
  logic [OP_W-1:0]                wum__wud__op;
  logic [NUM_OPT*OPT_TYPE_W-1:0]  wum__wud__option_type;
  logic [NUM_OPT*OPT_VALUE_W-1:0] wum__wud__option_value;
`ifdef WU_MEMORY_QUEUE_PARITY_EN
  logic                           wum__sys__parity_err;
`endif

  modport master (
    output sys__mgr__mgrId, wuf__wum__read, wuf__wum__addr, wuf__wum__flush,
    output ld__wum__write, ld__wum__addr, ld__wum__data, wud__wum__ready,
    input  wum__wuf__stall, wum__wud__valid, wum__wud__icntl, wum__wud__dcntl,
    input  wum__wud__op, wum__wud__option_type, wum__wud__option_value
`ifdef WU_MEMORY_QUEUE_PARITY_EN
    , input wum__sys__parity_err
`endif
  );

  modport slave (
    input  sys__mgr__mgrId, wuf__wum__read, wuf__wum__addr, wuf__wum__flush,
    input  ld__wum__write, ld__wum__addr, ld__wum__data, wud__wum__ready,
    output wum__wuf__stall, wum__wud__valid, wum__wud__icntl, wum__wud__dcntl,
    output wum__wud__op, wum__wud__option_type, wum__wud__option_value
`ifdef WU_MEMORY_QUEUE_PARITY_EN
    , output wum__sys__parity_err
`endif
  );
endinterface

// File: rtl/wu_memory_queue_fifo.sv
// Circular DEPTH x W buffer; push visible next cycle, head read combinationally.
// No internal backpressure: the caller's credit scheme guarantees no push when full.
module wu_memory_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 54
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [W-1:0]               head_dat_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wrap_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = wrap_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) buf_q[wr_ptr_q] <= push_dat_i;
  end

  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = buf_q[rd_ptr_q];
endmodule

// File: rtl/wu_memory_queue.sv
// WU instruction store: 1R1W array, 2-cycle read pipeline into a credit-guarded output FIFO.
// Stall is registered-only and asserted at FIFO_DEPTH credits; optional parity via WU_MEMORY_QUEUE_PARITY_EN.
module wu_memory_queue
  import wu_memory_queue_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int NUM_OPT     = 3,
  parameter int OPT_TYPE_W  = 8,
  parameter int OPT_VALUE_W = 8,
  parameter int OP_W        = 2,
  parameter int CNTL_W      = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int MGR_ID_W    = 8
) (
  input logic              clk,
  input logic              reset_poweron,
  wu_memory_queue_if.slave bus
);
  localparam int WORD_W = word_w(NUM_OPT, OPT_TYPE_W, OPT_VALUE_W, OP_W, CNTL_W);
  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int OPT_W  = OPT_TYPE_W + OPT_VALUE_W;
`ifdef WU_MEMORY_QUEUE_PARITY_EN
  localparam int MEM_W  = WORD_W + 1;
`else
  localparam int MEM_W  = WORD_W;
`endif

  logic [MEM_W-1:0]  mem_q [MEM_DEPTH];
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  r1_word_q, r2_word_q;
  logic              r1_vld_q, r1_vld_d, r2_vld_q, r2_vld_d;
  logic              init_done_q;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic              stall, accept, pop, push, flush;
  logic              fifo_empty;
  logic [CRED_W-1:0] fifo_cnt;
  logic [WORD_W-1:0] fifo_head, head_word;

  assign flush  = bus.wuf__wum__flush;
  assign stall  = reset_poweron | ~init_done_q | (credits_q == CRED_W'(FIFO_DEPTH));
  assign accept = bus.wuf__wum__read & ~stall & ~flush;
  assign pop    = ~fifo_empty & bus.wud__wum__ready;
  assign push   = r2_vld_q & ~flush;

`ifdef WU_MEMORY_QUEUE_PARITY_EN
  assign wr_word = {^bus.ld__wum__data, bus.ld__wum__data};
`else
  assign wr_word = bus.ld__wum__data;
`endif

  // Array read is sampled at the accept edge so a same-edge load write returns the old word.
  always_ff @(posedge clk) begin
    if (bus.ld__wum__write) mem_q[bus.ld__wum__addr] <= wr_word;
    if (accept) r1_word_q <= mem_q[bus.wuf__wum__addr];
    r2_word_q <= r1_word_q;
  end

  always_comb begin
    r1_vld_d  = accept;
    r2_vld_d  = r1_vld_q & ~flush;
    credits_d = flush ? '0 : credits_q + CRED_W'(accept) - CRED_W'(pop);
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      init_done_q <= 1'b0;
      r1_vld_q    <= 1'b0;
      r2_vld_q    <= 1'b0;
      credits_q   <= '0;
    end else begin
      init_done_q <= 1'b1;
      r1_vld_q    <= r1_vld_d;
      r2_vld_q    <= r2_vld_d;
      credits_q   <= credits_d;
    end
  end

`ifdef WU_MEMORY_QUEUE_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    parity_err_d = parity_err_q | (push & (^r2_word_q));
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) parity_err_q <= 1'b0;
    else               parity_err_q <= parity_err_d;
  end

  assign bus.wum__sys__parity_err = parity_err_q;
`endif

  wu_memory_queue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset_poweron),
    .push_i     (push),
    .push_dat_i (r2_word_q[WORD_W-1:0]),
    .pop_i      (pop),
    .flush_i    (flush),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt),
    .head_dat_o (fifo_head)
  );

  assign head_word           = fifo_empty ? '0 : fifo_head;
  assign bus.wum__wuf__stall = stall;
  assign bus.wum__wud__valid = ~fifo_empty;
  assign bus.wum__wud__icntl = head_word[icntl_lsb() +: CNTL_W];
  assign bus.wum__wud__dcntl = head_word[dcntl_lsb(CNTL_W) +: CNTL_W];
  assign bus.wum__wud__op    = head_word[op_lsb(CNTL_W) +: OP_W];

  for (genvar i = 0; i < NUM_OPT; i++) begin : g_opt
    assign bus.wum__wud__option_type[i*OPT_TYPE_W +: OPT_TYPE_W] =
      head_word[opt_lsb(CNTL_W, OP_W) + i*OPT_W +: OPT_TYPE_W];
    assign bus.wum__wud__option_value[i*OPT_VALUE_W +: OPT_VALUE_W] =
      head_word[opt_lsb(CNTL_W, OP_W) + i*OPT_W + OPT_TYPE_W +: OPT_VALUE_W];
  end

  // Queued words never exceed outstanding credits; the manager id never moves while running.
  a_credit_bound: assert property (@(posedge clk) disable iff (reset_poweron)
    fifo_cnt <= credits_q);
  a_mgr_id_static: assert property (@(posedge clk) disable iff (reset_poweron)
    $stable(bus.sys__mgr__mgrId));
endmodule
